// File: rtl/filtro_iir_pkg.sv
// Shared types and constants for the cascaded biquad IIR filter:
// sequencer states, MAC operations and coefficient slot indices.
package filtro_iir_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        FB1  = 3'd1,
        FB2  = 3'd2,
        WSAT = 3'd3,
        FF0  = 3'd4,
        FF1  = 3'd5,
        FF2  = 3'd6,
        YSAT = 3'd7
    } estado_e;

    typedef enum logic [2:0] {
        MAC_NOP  = 3'd0,
        MAC_XSUB = 3'd1,
        MAC_SUB  = 3'd2,
        MAC_LOAD = 3'd3,
        MAC_ADD  = 3'd4
    } mac_op_e;

    localparam int B0 = 0;
    localparam int B1 = 1;
    localparam int B2 = 2;
    localparam int A1 = 3;
    localparam int A2 = 4;
    localparam int COEF_POR_SECCION = 5;

endpackage

// File: rtl/filtro_iir_cascada_mac.sv
// Shared multiply-accumulate unit: one signed multiplier, a guarded accumulator
// and the shift-by-FRAC / saturate stage that produces w and y.
module iir_mac
#(
    parameter int N     = 25,
    parameter int FRAC  = 22,
    parameter int GUARD = 4
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic [2:0]   op_i,
    input  logic [N-1:0] coef_i,
    input  logic [N-1:0] dato_i,
    input  logic [N-1:0] x_i,
    output logic [N-1:0] sat_val_o,
    output logic         sat_flag_o
);
    import filtro_iir_pkg::*;

    localparam int AW = 2*N + GUARD;

    logic [AW-1:0]  acc_q;
    logic [AW-1:0]  acc_d;
    logic [AW-1:0]  prod_ext_s;
    logic [AW-1:0]  x_ext_s;
    logic [AW-1:0]  desplazado_s;
    logic [2*N-1:0] coef_ext_s;
    logic [2*N-1:0] dato_ext_s;
    logic [2*N-1:0] prod_s;
    logic [N:0]     sat_s;

    // Returns {overflow, value}; in range when all bits from N-1 upward agree.
    function automatic logic [N:0] saturar(input logic [AW-1:0] v);
        logic [AW-N:0] alto;
        alto = v[AW-1:N-1];
        if (&alto || ~|alto) begin
            saturar = {1'b0, v[N-1:0]};
        end else if (v[AW-1]) begin
            saturar = {1'b1, 1'b1, {(N-1){1'b0}}};
        end else begin
            saturar = {1'b1, 1'b0, {(N-1){1'b1}}};
        end
    endfunction

    // Low 2N bits of the sign-extended product equal the signed product.
    assign coef_ext_s   = {{N{coef_i[N-1]}}, coef_i};
    assign dato_ext_s   = {{N{dato_i[N-1]}}, dato_i};
    assign prod_s       = coef_ext_s * dato_ext_s;
    assign prod_ext_s   = {{GUARD{prod_s[2*N-1]}}, prod_s};
    assign x_ext_s      = {{(AW-N-FRAC){x_i[N-1]}}, x_i, {FRAC{1'b0}}};
    assign desplazado_s = $signed(acc_q) >>> FRAC;
    assign sat_s        = saturar(desplazado_s);
    assign sat_val_o    = sat_s[N-1:0];
    assign sat_flag_o   = sat_s[N];

    // Accumulator next-value selection.
    always_comb begin
        acc_d = acc_q;
        case (op_i)
            MAC_XSUB: acc_d = x_ext_s - prod_ext_s;
            MAC_SUB:  acc_d = acc_q - prod_ext_s;
            MAC_LOAD: acc_d = prod_ext_s;
            MAC_ADD:  acc_d = acc_q + prod_ext_s;
            default:  acc_d = acc_q;
        endcase
    end

    // Accumulator register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/filtro_iir_cascada.sv
// Cascade of SECCIONES direct-form-II biquads sharing one MAC; each section
// takes seven cycles and its output feeds the next section's input.
module filtro_iir_cascada
    import filtro_iir_pkg::*;
#(
    parameter int N         = 25,
    parameter int FRAC      = 22,
    parameter int SECCIONES = 2,
    parameter int GUARD     = 4
) (
    input  logic         Clk,
    input  logic         Reset_n,
    input  logic [N-1:0] Uk,
    input  logic         Bandera_ADC,
    input  logic         Coef_We,
    input  logic [5:0]   Coef_Addr,
    input  logic [N-1:0] Coef_Data,
    output logic [N-1:0] Yk,
    output logic         Bandera_Listo,
    output logic         Ocupado,
    output logic         Saturo,
    output logic         Overrun
);

    localparam int SW = (SECCIONES > 1) ? $clog2(SECCIONES) : 1;
    localparam logic [N-1:0] COEF_UNO = {{(N-1){1'b0}}, 1'b1} << FRAC;

    estado_e        estado_q;
    logic [SW-1:0]  sec_q;
    logic [N-1:0]   x_q;
    logic [N-1:0]   w_q;
    logic [N-1:0]   yk_q;
    logic           listo_q;
    logic           ocupado_q;
    logic           saturo_q;
    logic           overrun_q;
    logic [N-1:0]   w1_q   [SECCIONES];
    logic [N-1:0]   w2_q   [SECCIONES];
    logic [N-1:0]   coef_q [SECCIONES][COEF_POR_SECCION];

    mac_op_e        mac_op_s;
    logic [N-1:0]   coef_sel_s;
    logic [N-1:0]   dato_sel_s;
    logic [N-1:0]   sat_val_s;
    logic           sat_flag_s;
    logic           escribir_s;

    assign Yk            = yk_q;
    assign Bandera_Listo = listo_q;
    assign Ocupado       = ocupado_q;
    assign Saturo        = saturo_q;
    assign Overrun       = overrun_q;

    // A start takes priority over a coefficient write in the same cycle.
    assign escribir_s = Coef_We && (estado_q == IDLE) && !Bandera_ADC;

    // Operand and operation selection for the shared MAC.
    always_comb begin
        mac_op_s   = MAC_NOP;
        coef_sel_s = '0;
        dato_sel_s = '0;
        case (estado_q)
            FB1: begin mac_op_s = MAC_XSUB; coef_sel_s = coef_q[sec_q][A1]; dato_sel_s = w1_q[sec_q]; end
            FB2: begin mac_op_s = MAC_SUB;  coef_sel_s = coef_q[sec_q][A2]; dato_sel_s = w2_q[sec_q]; end
            FF0: begin mac_op_s = MAC_LOAD; coef_sel_s = coef_q[sec_q][B0]; dato_sel_s = w_q;         end
            FF1: begin mac_op_s = MAC_ADD;  coef_sel_s = coef_q[sec_q][B1]; dato_sel_s = w1_q[sec_q]; end
            FF2: begin mac_op_s = MAC_ADD;  coef_sel_s = coef_q[sec_q][B2]; dato_sel_s = w2_q[sec_q]; end
            default: begin mac_op_s = MAC_NOP; coef_sel_s = '0; dato_sel_s = '0; end
        endcase
    end

    iir_mac #(.N(N), .FRAC(FRAC), .GUARD(GUARD)) u_mac (
        .clk_i      (Clk),
        .rst_ni     (Reset_n),
        .op_i       (mac_op_s),
        .coef_i     (coef_sel_s),
        .dato_i     (dato_sel_s),
        .x_i        (x_q),
        .sat_val_o  (sat_val_s),
        .sat_flag_o (sat_flag_s)
    );

    // Sequencer, delay lines, coefficient bank and registered outputs.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            estado_q  <= IDLE;
            sec_q     <= '0;
            x_q       <= '0;
            w_q       <= '0;
            yk_q      <= '0;
            listo_q   <= 1'b0;
            ocupado_q <= 1'b0;
            saturo_q  <= 1'b0;
            overrun_q <= 1'b0;
            for (int s = 0; s < SECCIONES; s++) begin
                w1_q[s] <= '0;
                w2_q[s] <= '0;
                for (int k = 0; k < COEF_POR_SECCION; k++) begin
                    coef_q[s][k] <= (k == B0) ? COEF_UNO : '0;
                end
            end
        end else begin
            listo_q   <= 1'b0;
            overrun_q <= Bandera_ADC && ocupado_q;
            if (escribir_s) begin
                for (int s = 0; s < SECCIONES; s++) begin
                    for (int k = 0; k < COEF_POR_SECCION; k++) begin
                        if (Coef_Addr == 6'(s*COEF_POR_SECCION + k)) begin
                            coef_q[s][k] <= Coef_Data;
                        end
                    end
                end
            end
            case (estado_q)
                IDLE: begin
                    if (Bandera_ADC) begin
                        x_q       <= Uk;
                        sec_q     <= '0;
                        saturo_q  <= 1'b0;
                        ocupado_q <= 1'b1;
                        estado_q  <= FB1;
                    end else begin
                        estado_q  <= IDLE;
                    end
                end
                FB1:  estado_q <= FB2;
                FB2:  estado_q <= WSAT;
                WSAT: begin
                    w_q <= sat_val_s;
                    if (sat_flag_s) begin
                        saturo_q <= 1'b1;
                    end
                    estado_q <= FF0;
                end
                FF0:  estado_q <= FF1;
                FF1:  estado_q <= FF2;
                FF2:  estado_q <= YSAT;
                YSAT: begin
                    w2_q[sec_q] <= w1_q[sec_q];
                    w1_q[sec_q] <= w_q;
                    if (sat_flag_s) begin
                        saturo_q <= 1'b1;
                    end
                    if (sec_q == SW'(SECCIONES-1)) begin
                        yk_q      <= sat_val_s;
                        listo_q   <= 1'b1;
                        ocupado_q <= 1'b0;
                        estado_q  <= IDLE;
                    end else begin
                        x_q      <= sat_val_s;
                        sec_q    <= sec_q + 1'b1;
                        estado_q <= FB1;
                    end
                end
                default: begin
                    ocupado_q <= 1'b0;
                    estado_q  <= IDLE;
                end
            endcase
        end
    end

endmodule
